// File: rtl/apx_pkg.sv
// Shared defaults, encoded-operand type and leading-one helper for the
// rounding approximate multiplier front end.
package apx_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int LOG2_WIDTH_DEF = 4;

  typedef struct packed {
    logic [LOG2_WIDTH_DEF-1:0] k;
    logic                      decision_bit;
    logic                      zero;
  } enc_operand_t;

  // Index of the highest set bit; 0 when no bit is set (zero reported separately).
  function automatic int unsigned lead_one_idx(input logic [63:0] x);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (x[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/leading_one_detector.sv
// Combinational priority encoder: X -> {K, zero}. WIDTH must be below 64.
module leading_one_detector
  import apx_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int LOG2_WIDTH = LOG2_WIDTH_DEF
) (
  input  logic [WIDTH-1:0]      x,
  output logic [LOG2_WIDTH-1:0] k,
  output logic                  zero
);

  assign zero = (x == '0);
  assign k    = LOG2_WIDTH'(lead_one_idx(64'(x)));

endmodule

// File: rtl/operand_round_encoder.sv
// Two-stage operand encoder: S1 holds X/Y, S2 holds {K, decision_bit, zero, Y}.
// Define APX_ROUND_EN to round up to 2^(K+1); otherwise decision_bit stays 0.
module operand_round_encoder
  import apx_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int ROUN_WIDTH = 0,
  parameter int LOG2_WIDTH = LOG2_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            X,
  input  logic [WIDTH+ROUN_WIDTH-1:0] Y,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LOG2_WIDTH-1:0]       K,
  output logic                        decision_bit,
  output logic                        zero,
  output logic [WIDTH+ROUN_WIDTH-1:0] Y_out
);

  logic                        s1_valid;
  logic [WIDTH-1:0]            s1_x;
  logic [WIDTH+ROUN_WIDTH-1:0] s1_y;

  logic                        s2_valid;
  logic [LOG2_WIDTH-1:0]       s2_k;
  logic                        s2_dec;
  logic                        s2_zero;
  logic [WIDTH+ROUN_WIDTH-1:0] s2_y;

  logic                  s2_can_load;
  logic                  s1_can_load;
  logic [LOG2_WIDTH-1:0] lod_k;
  logic                  lod_zero;
  logic                  dec_next;

  // S2 frees up either when empty or when its result is taken this cycle,
  // so in_ready is deliberately combinational from out_ready.
  assign s2_can_load = !s2_valid || out_ready;
  assign s1_can_load = !s1_valid || s2_can_load;
  assign in_ready    = s1_can_load;

  leading_one_detector #(
    .WIDTH      (WIDTH),
    .LOG2_WIDTH (LOG2_WIDTH)
  ) u_lod (
    .x    (s1_x),
    .k    (lod_k),
    .zero (lod_zero)
  );

`ifdef APX_ROUND_EN
  always_comb begin
    dec_next = 1'b0;
    if (lod_k != '0) dec_next = s1_x[lod_k - LOG2_WIDTH'(1)];
  end
`else
  assign dec_next = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_y     <= '0;
    end else if (s1_can_load) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x <= X;
        s1_y <= Y;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_k     <= '0;
      s2_dec   <= 1'b0;
      s2_zero  <= 1'b0;
      s2_y     <= '0;
    end else if (s2_can_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_k    <= lod_k;
        s2_dec  <= dec_next;
        s2_zero <= lod_zero;
        s2_y    <= s1_y;
      end
    end
  end

  assign out_valid    = s2_valid;
  assign K            = s2_k;
  assign decision_bit = s2_dec;
  assign zero         = s2_zero;
  assign Y_out        = s2_y;

endmodule

// File: tb/tb_operand_round_encoder.sv
// Directed bench for operand_round_encoder (WIDTH=16, ROUN_WIDTH=0) with an
// in-order scoreboard of hand-computed expectations.
module tb_operand_round_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] X;
  logic [15:0] Y;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  K;
  logic        decision_bit;
  logic        zero;
  logic [15:0] Y_out;

  operand_round_encoder #(
    .WIDTH      (16),
    .ROUN_WIDTH (0),
    .LOG2_WIDTH (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .X            (X),
    .Y            (Y),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .K            (K),
    .decision_bit (decision_bit),
    .zero         (zero),
    .Y_out        (Y_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  k;
    logic        dec;
    logic        z;
    logic [15:0] y;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [3:0]  k;
    logic        dec;
    logic        z;
  } vec_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc_n  = 0;
  exp_t q[$];
  int   pop_cyc[$];
  exp_t cur_exp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cyc_n);
    end
  endtask

  function automatic logic dsel(input logic d);
`ifdef APX_ROUND_EN
    return d;
`else
    return 1'b0;
`endif
  endfunction

  // Scoreboard: every valid output cycle must match the head expectation,
  // which also proves fields hold while stalled.
  always @(negedge clk) begin
    cyc_n++;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          chk("K", K, q[0].k);
          chk("decision_bit", decision_bit, q[0].dec);
          chk("zero", zero, q[0].z);
          chk("Y_out", Y_out, q[0].y);
          if (out_ready) begin
            void'(q.pop_front());
            pop_cyc.push_back(cyc_n);
          end
        end
      end
      if (in_valid && in_ready) q.push_back(cur_exp);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v, input logic [15:0] y);
    in_valid    = 1'b1;
    X           = v.x;
    Y           = y;
    cur_exp.k   = v.k;
    cur_exp.dec = dsel(v.dec);
    cur_exp.z   = v.z;
    cur_exp.y   = y;
  endtask

  task automatic send(input vec_t v, input logic [15:0] y);
    logic ok;
    drive(v, y);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      ok = in_ready;
      cyc();
      if (ok) break;
      if (i == 49) chk("send_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && q.size() != 0; i++) cyc();
    chk("drain_empty", q.size(), 0);
  endtask

  vec_t single_v[5] = '{
    '{16'h0013, 4'd4,  1'b0, 1'b0},
    '{16'h001C, 4'd4,  1'b1, 1'b0},
    '{16'h0000, 4'd0,  1'b0, 1'b1},
    '{16'h0001, 4'd0,  1'b0, 1'b0},
    '{16'hC000, 4'd15, 1'b1, 1'b0}
  };

  vec_t stream_v[8] = '{
    '{16'h0002, 4'd1,  1'b0, 1'b0},
    '{16'h0003, 4'd1,  1'b1, 1'b0},
    '{16'h8000, 4'd15, 1'b0, 1'b0},
    '{16'h00FF, 4'd7,  1'b1, 1'b0},
    '{16'h0100, 4'd8,  1'b0, 1'b0},
    '{16'h0A00, 4'd11, 1'b0, 1'b0},
    '{16'h7FFF, 4'd14, 1'b1, 1'b0},
    '{16'h0040, 4'd6,  1'b0, 1'b0}
  };

  vec_t bp_v[4] = '{
    '{16'h0600, 4'd10, 1'b1, 1'b0},
    '{16'h0005, 4'd2,  1'b0, 1'b0},
    '{16'h0030, 4'd5,  1'b1, 1'b0},
    '{16'h4000, 4'd14, 1'b0, 1'b0}
  };

  vec_t rst_v[3] = '{
    '{16'h1234, 4'd12, 1'b0, 1'b0},
    '{16'hFFFF, 4'd15, 1'b1, 1'b0},
    '{16'h0009, 4'd3,  1'b0, 1'b0}
  };

  initial begin
    int idx;
    int first_pop;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    X         = '0;
    Y         = '0;
    cur_exp   = '{4'd0, 1'b0, 1'b0, 16'd0};
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_K", K, 4'd0);
    chk("rst_decision_bit", decision_bit, 1'b0);
    chk("rst_zero", zero, 1'b0);
    chk("rst_Y_out", Y_out, 16'd0);

    // Latency: accept on edge P0, result visible after P1.
    cyc();
    drive(single_v[0], 16'h0005);
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lat_cycle1_out_valid", out_valid, 1'b0);
    cyc();
    @(negedge clk);
    chk("lat_cycle2_out_valid", out_valid, 1'b1);
    drain();

    for (int i = 1; i < 5; i++) send(single_v[i], 16'h0100 + 16'(i));
    drain();

    // Back-to-back stream: one result per cycle.
    first_pop = pop_cyc.size();
    for (int i = 0; i < 8; i++) send(stream_v[i], 16'hA000 + 16'(i));
    drain();
    chk("stream_count", pop_cyc.size() - first_pop, 8);
    chk("stream_span", pop_cyc[pop_cyc.size()-1] - pop_cyc[first_pop], 7);

    // Backpressure from an empty pipeline: exactly two accepts, then stall.
    idx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(bp_v[idx], 16'hB000 + 16'(idx));
      @(negedge clk);
      if (in_ready) idx++;
      cyc();
    end
    chk("bp_accepts", idx, 2);
    @(negedge clk);
    chk("bp_in_ready_low", in_ready, 1'b0);
    cyc();
    out_ready = 1'b1;
    for (int c = 0; c < 20 && idx < 4; c++) begin
      drive(bp_v[idx], 16'hB000 + 16'(idx));
      @(negedge clk);
      if (in_ready) idx++;
      cyc();
    end
    in_valid = 1'b0;
    chk("bp_all_sent", idx, 4);
    drain();

    // Flush both full stages with reset.
    out_ready = 1'b0;
    send(rst_v[0], 16'hC001);
    send(rst_v[1], 16'hC002);
    @(negedge clk);
    chk("pre_rst_full", {out_valid, in_ready}, 2'b10);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", out_valid, 1'b0);
    chk("post_rst_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    repeat (4) cyc();
    send(rst_v[2], 16'hC003);
    drain();
    chk("post_rst_pop_total", pop_cyc.size(), 18);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
